// File: rtl/display_pkg.sv
// Shared display constants: digit count, blank codes, hex segment patterns, scan states.
package display_pkg;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned HEX_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DATA_W = NDIG * HEX_W;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [NDIG-1:0]  AN_OFF    = 4'b1111;

    // Active-low a..g patterns, seg[6]=a ... seg[0]=g
    localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_HEX_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_HEX_B = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_HEX_C = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_HEX_D = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_HEX_E = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_HEX_F = 7'b0111000;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Display contents as four hex nibbles, digit0 in the low nibble
    typedef logic [NDIG-1:0][HEX_W-1:0] digits_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Display-contents update handshake between the sequencer and the scan controller.
interface display_scan_ctrl_if;
    import display_pkg::*;

    logic              upd_req;
    logic [DATA_W-1:0] upd_data;
    logic [NDIG-1:0]   upd_mask;
    logic              upd_ack;

    modport master (
        output upd_req,
        output upd_data,
        output upd_mask,
        input  upd_ack
    );

    modport slave (
        input  upd_req,
        input  upd_data,
        input  upd_mask,
        output upd_ack
    );

endinterface

// File: rtl/seg7_decode.sv
// Hex code to active-low 7-segment pattern; purely combinational.
module seg7_decode
    import display_pkg::*;
(
    input  logic [HEX_W-1:0] code,
    output logic [SEG_W-1:0] seg_c
);

    // Table lookup for all 16 hex codes
    always_comb begin
        seg_c = SEG_BLANK;
        case (code)
            4'h0: seg_c = SEG_HEX_0;
            4'h1: seg_c = SEG_HEX_1;
            4'h2: seg_c = SEG_HEX_2;
            4'h3: seg_c = SEG_HEX_3;
            4'h4: seg_c = SEG_HEX_4;
            4'h5: seg_c = SEG_HEX_5;
            4'h6: seg_c = SEG_HEX_6;
            4'h7: seg_c = SEG_HEX_7;
            4'h8: seg_c = SEG_HEX_8;
            4'h9: seg_c = SEG_HEX_9;
            4'hA: seg_c = SEG_HEX_A;
            4'hB: seg_c = SEG_HEX_B;
            4'hC: seg_c = SEG_HEX_C;
            4'hD: seg_c = SEG_HEX_D;
            4'hE: seg_c = SEG_HEX_E;
            4'hF: seg_c = SEG_HEX_F;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with per-slot blanking guard
// and frame-aligned loading of new display contents.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic               CLK,
    input  logic               rst,
    display_scan_ctrl_if.slave upd,
    output logic [SEG_W-1:0]   seg,
    output logic [NDIG-1:0]    an,
    output logic [IDX_W-1:0]   digit_idx,
    output logic               frame_tick
);

    localparam int unsigned     CNT_W      = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic            BLANK_EN   = (BLANK_CYC != 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] idx;
    scan_state_e      state;
    digits_t          shadow;
    logic [NDIG-1:0]  mask;

    logic             slot_end;
    logic             frame_end;
    logic             lit;
    logic [SEG_W-1:0] cur_seg;

    assign slot_end  = (count == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign lit       = (state == DRIVE) && mask[idx];

    seg7_decode u_dec (
        .code  (shadow[idx]),
        .seg_c (cur_seg)
    );

    // Slot counter, digit index, blank/drive FSM, frame-aligned capture and registered outputs
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            idx         <= '0;
            state       <= BLANK;
            shadow      <= '0;
            mask        <= '0;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            digit_idx   <= '0;
            frame_tick  <= 1'b0;
            upd.upd_ack <= 1'b0;
        end else begin
            count <= slot_end ? '0 : count + CNT_W'(1);
            if (slot_end) begin
                idx <= idx + IDX_W'(1);
            end

            case (state)
                BLANK: begin
                    if (!BLANK_EN || (count == BLANK_LAST)) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_end && BLANK_EN) begin
                        state <= BLANK;
                    end
                end
                default: state <= BLANK;
            endcase

            // Outputs reflect the pre-edge state/count/idx, so they trail by one cycle
            an          <= lit ? ~(NDIG'(1) << idx) : AN_OFF;
            seg         <= lit ? cur_seg : SEG_BLANK;
            digit_idx   <= idx;
            frame_tick  <= frame_end;
            upd.upd_ack <= frame_end && upd.upd_req;

            // New contents only take effect at a frame boundary
            if (frame_end && upd.upd_req) begin
                shadow <= digits_t'(upd.upd_data);
                mask   <= upd.upd_mask;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a frame/slot reference model.
module tb_display_scan_ctrl;

    localparam int P  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * P;

    localparam logic [14:0] RST_V = {4'b1111, 7'b1111111, 2'b00, 1'b0, 1'b0};

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    display_scan_ctrl_if bus ();
    display_scan_ctrl_if bus0 ();

    logic [6:0] seg, seg0;
    logic [3:0] an, an0;
    logic [1:0] didx, didx0;
    logic       ft, ft0;

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(B)) dut (
        .CLK        (clk),
        .rst        (rst),
        .upd        (bus),
        .seg        (seg),
        .an         (an),
        .digit_idx  (didx),
        .frame_tick (ft)
    );

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYC(0)) dut0 (
        .CLK        (clk),
        .rst        (rst),
        .upd        (bus0),
        .seg        (seg0),
        .an         (an0),
        .digit_idx  (didx0),
        .frame_tick (ft0)
    );

    logic [14:0] obs, obs0;
    assign obs  = {an, seg, didx, ft, bus.upd_ack};
    assign obs0 = {an0, seg0, didx0, ft0, bus0.upd_ack};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n;
    logic [15:0] sh, sh0;
    logic [3:0]  mk, mk0;
    logic [14:0] exp_v, exp0_v;

    // Expected {an, seg, digit_idx, frame_tick} after edge e since reset release
    function automatic logic [13:0] model_out(input int e, input int b,
                                              input logic [15:0] d, input logic [3:0] m);
        int         pos;
        int         dig;
        logic [3:0] a;
        logic [6:0] s;
        pos = e % P;
        dig = (e / P) % 4;
        a = 4'b1111;
        s = 7'b1111111;
        if (!(pos < b || (b == 0 && e == 0)) && m[dig]) begin
            a[dig] = 1'b0;
            s = SEG_TAB[d[4*dig +: 4]];
        end
        return {a, s, 2'(dig), 1'((e % FR) == FR - 1)};
    endfunction

    // Advance one clock edge and update the model; leaves time at edge + 1
    task automatic step();
        @(posedge clk);
        exp_v  = {model_out(n, B, sh, mk),   1'((n % FR == FR - 1) && bus.upd_req)};
        exp0_v = {model_out(n, 0, sh0, mk0), 1'((n % FR == FR - 1) && bus0.upd_req)};
        if (exp_v[0]) begin
            sh = bus.upd_data;
            mk = bus.upd_mask;
        end
        if (exp0_v[0]) begin
            sh0 = bus0.upd_data;
            mk0 = bus0.upd_mask;
        end
        n++;
        #1;
    endtask

    task automatic model_reset();
        n = 0;
        sh = '0; mk = '0;
        sh0 = '0; mk0 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.upd_req = 1'b0;  bus.upd_data = '0;  bus.upd_mask = '0;
        bus0.upd_req = 1'b0; bus0.upd_data = '0; bus0.upd_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({obs, obs0} !== {RST_V, RST_V}) begin
            n_bad++;
            $display("FAIL reset_state got %b/%b want %b/%b", obs, obs0, RST_V, RST_V);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL idle edge=%0d an,seg,idx,tick,ack got %b want %b", n - 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_update();
        int waited;
        bit acked;
        waited = 0;
        acked = 1'b0;
        @(negedge clk);
        bus.upd_req = 1'b1; bus.upd_data = 16'h4321; bus.upd_mask = 4'b1111;
        while (!acked && waited < FR + 2) begin
            step();
            waited++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL update_wait edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
            if (bus.upd_ack) begin
                acked = 1'b1;
                bus.upd_req = 1'b0;
            end
        end
        n_cmp++;
        if (!acked) begin
            n_bad++;
            $display("FAIL update_ack_timeout got no ack in %0d cycles want ack", waited);
        end
        for (int i = 0; i < FR + 4; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL update_frame edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_midframe();
        int waited;
        bit acked;
        waited = 0;
        acked = 1'b0;
        while (((n / P) % 4) != 1 && waited < FR) begin
            step();
            waited++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midframe_idle edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
        repeat ($urandom_range(0, P - 1)) step();
        bus.upd_data = 16'($urandom);
        bus.upd_mask = 4'($urandom_range(1, 15));
        bus.upd_req  = 1'b1;
        waited = 0;
        while (!acked && waited < FR + 2) begin
            step();
            waited++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midframe_wait edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
            if (bus.upd_ack) begin
                acked = 1'b1;
                bus.upd_req = 1'b0;
                n_cmp++;
                if (ft !== 1'b1) begin
                    n_bad++;
                    $display("FAIL midframe_ack_vs_tick got tick=%b want 1", ft);
                end
            end
        end
        n_cmp++;
        if (!acked) begin
            n_bad++;
            $display("FAIL midframe_ack_timeout got no ack in %0d cycles want ack", waited);
        end
        for (int i = 0; i < FR; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL midframe_frame edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_mask();
        int waited;
        bit acked;
        waited = 0;
        acked = 1'b0;
        bus.upd_req = 1'b1; bus.upd_data = 16'h8888; bus.upd_mask = 4'b0101;
        while (!acked && waited < FR + 2) begin
            step();
            waited++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL mask_wait edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
            if (bus.upd_ack) begin
                acked = 1'b1;
                bus.upd_req = 1'b0;
            end
        end
        n_cmp++;
        if (!acked) begin
            n_bad++;
            $display("FAIL mask_ack_timeout got no ack in %0d cycles want ack", waited);
        end
        for (int i = 0; i < FR + 4; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL mask_frame edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int gap;
        int hold;
        for (int k = 0; k < 8; k++) begin
            gap = $urandom_range(0, 40);
            for (int i = 0; i < gap; i++) begin
                step();
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL random_gap it=%0d edge=%0d got %b want %b", k, n - 1, obs, exp_v);
                end
            end
            bus.upd_data = 16'($urandom);
            bus.upd_mask = 4'($urandom_range(1, 15));
            bus.upd_req  = 1'b1;
            hold = $urandom_range(1, 40);
            for (int i = 0; i < hold && bus.upd_req; i++) begin
                step();
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL random_req it=%0d edge=%0d got %b want %b", k, n - 1, obs, exp_v);
                end
                if (bus.upd_ack) bus.upd_req = 1'b0;
            end
            bus.upd_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        bit acked;
        waited = 0;
        acked = 1'b0;
        while (exp_v[14:11] == 4'b1111 && waited < 2 * FR) begin
            step();
            waited++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_pre edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
        n_cmp++;
        if (an === 4'b1111) begin
            n_bad++;
            $display("FAIL rstmid_no_drive got an=%b want a lit digit", an);
        end
        bus.upd_data = 16'($urandom);
        bus.upd_mask = 4'b1111;
        bus.upd_req  = 1'b1;
        #1;
        rst = 1'b0;
        bus.upd_req = 1'b0;
        #1;
        n_cmp++;
        if ({obs, obs0} !== {RST_V, RST_V}) begin
            n_bad++;
            $display("FAIL rstmid_async got %b/%b want %b/%b", obs, obs0, RST_V, RST_V);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < FR + 8; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_after edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
        bus.upd_req = 1'b1;
        waited = 0;
        while (!acked && waited < FR + 2) begin
            step();
            waited++;
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_rereq edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
            if (bus.upd_ack) begin
                acked = 1'b1;
                bus.upd_req = 1'b0;
            end
        end
        n_cmp++;
        if (!acked) begin
            n_bad++;
            $display("FAIL rstmid_ack_timeout got no ack in %0d cycles want ack", waited);
        end
        for (int i = 0; i < FR; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL rstmid_frame edge=%0d got %b want %b", n - 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_noblank();
        int waited;
        bit acked;
        waited = 0;
        acked = 1'b0;
        bus0.upd_data = 16'($urandom);
        bus0.upd_mask = 4'b1111;
        bus0.upd_req  = 1'b1;
        while (!acked && waited < FR + 2) begin
            step();
            waited++;
            n_cmp++;
            if (obs0 !== exp0_v) begin
                n_bad++;
                $display("FAIL noblank_wait edge=%0d got %b want %b", n - 1, obs0, exp0_v);
            end
            if (bus0.upd_ack) begin
                acked = 1'b1;
                bus0.upd_req = 1'b0;
            end
        end
        n_cmp++;
        if (!acked) begin
            n_bad++;
            $display("FAIL noblank_ack_timeout got no ack in %0d cycles want ack", waited);
        end
        step();
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            n_cmp++;
            if (obs0 !== exp0_v || an0 === 4'b1111) begin
                n_bad++;
                $display("FAIL noblank_scan edge=%0d got %b want %b", n - 1, obs0, exp0_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_v = RST_V;
        exp0_v = RST_V;
        model_reset();
        test_reset();
        test_update();
        test_midframe();
        test_mask();
        test_random();
        test_reset_mid();
        test_noblank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit, 7-segment display driven by the alarm/lock sequencer.
- Owns cathode bus (seg) and anode select (an). Cycles through digits at a fixed slot rate, with a blanking guard at the start of each slot to prevent ghosting.
- Accepts new display contents from the sequencer through a req/ack handshake. Updates are applied only at frame boundaries, so a frame never mixes old and new data.

Parameters:
- PRESCALE, 50000: CLK cycles per digit slot; legal range is PRESCALE >= 2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; must be < PRESCALE; 0 disables blanking.

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- upd_req  in  1  level request to load new display contents; held until upd_ack is seen.
- upd_data  in  16  four 4-bit hex codes; digit0 in [3:0], digit3 in [15:12].
- upd_mask  in  4  digit enable; bit i = 1 lights digit i.
- upd_ack  out  1  one-cycle pulse: contents captured.
- seg  out  7  active-low cathodes; seg[6]=a ... seg[0]=g.
- an  out  4  active-low anodes; an[i] = 0 selects digit i.
- digit_idx  out  2  digit currently scanned.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async, rst=0):
  - count=0, idx=0, state=BLANK.
  - Shadow data = 16'h0000, mask = 4'b0000.
  - an=4'b1111, seg=7'b1111111, upd_ack=0, frame_tick=0, digit_idx=0.
  - Applies immediately, including mid-slot or mid-handshake; a pending request is dropped and the requester must re-assert.
- Slot counter: count runs 0..PRESCALE-1, then wraps to 0.
- End of slot (count==PRESCALE-1): idx increments mod 4 (3->0 wraps).
- States:
  - BLANK while count < BLANK_CYC.
  - DRIVE otherwise.
  - BLANK->DRIVE when count==BLANK_CYC-1.
  - DRIVE->BLANK on slot end.
  - With BLANK_CYC=0 the block stays in DRIVE.
- Outputs are registered, 1-cycle latency from state/count/idx:
  - BLANK: an=1111, seg=1111111.
  - DRIVE: an = ~(1<<idx) if mask[idx]=1, else 1111. seg = decode(shadow[idx]) if mask[idx]=1, else 1111111.
- Frame boundary = the edge where count==PRESCALE-1 and idx==3. On that edge:
  - frame_tick <= 1 for one cycle.
  - If upd_req=1: shadow <= upd_data, mask <= upd_mask, upd_ack <= 1 for one cycle.
- upd_data and upd_mask must be stable while upd_req=1.
- A request arriving mid-frame waits, with no ack, up to one full frame (4*PRESCALE cycles).
- Requester drops upd_req the cycle after ack. If req is still high at the next boundary, data is recaptured and ack pulses again (level protocol; harmless).
- upd_req dropped before any boundary: no capture, no ack.
- Decode (hex, active-low a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- digit_idx is the registered copy of idx, aligned with an/seg.

Decomposition:
- Shared package display_pkg holds:
  - NDIG=4.
  - SEG_BLANK=7'b1111111, AN_OFF=4'b1111.
  - The 16 hex segment constants.
  - State encoding {BLANK, DRIVE}.
- One natural sub-module: seg7_decode (combinational 4-bit code -> 7-bit active-low segments), reusable by other display paths.
- Counter, FSM and handshake stay in display_scan_ctrl.

Test Plan (PRESCALE=8, BLANK_CYC=2 unless noted):
- Reset then idle 64 cycles -> an stays 1111, seg stays 1111111; frame_tick pulses every 32 cycles; upd_ack never pulses.
- upd_req=1, upd_data=16'h4321, upd_mask=1111 held until ack -> ack at first boundary. The next frame shows, per slot, 2 blank cycles then 6 driven cycles: an=1110/seg=1001111, then 1101/0010010, then 1011/0000110, then 0111/1001100.
- Request asserted mid-frame, at idx=1 -> no display change and no ack until the boundary; ack coincides with frame_tick.
- upd_mask=0101, data=16'h8888 -> digits 0 and 2 show 0000000; slots 1 and 3 keep an=1111, seg=1111111; the scan period is unchanged.
- rst pulled low during a DRIVE cycle with upd_req pending -> an=1111 and seg=1111111 asynchronously; after release, no ack until req is re-asserted and a boundary passes.
- BLANK_CYC=0 with full mask -> an is never 1111 between slots; slot changes occur exactly every 8 cycles.
